// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Imported by the fetch interface, skid register and top.
package ifetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [PC_W-1:0]    RESET_PC_DFLT = 32'h0000_0000;
    localparam logic [PC_W-1:0]    PC_STEP       = 32'd4;
    localparam logic [INSTR_W-1:0] NOP           = 32'h0000_0000;

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_LIVE,
        SLOT_HELD
    } slot_e;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

    function automatic logic misaligned(input logic [PC_W-1:0] pc);
        return |pc[1:0];
    endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus: ROM port, decode handshake, redirect/halt control.
// master = fetch sequencer, slave = ROM/decode/control environment.
interface ifetch_ctrl_if #(
    parameter int ADDR_W = 10
);
    import ifetch_pkg::*;

    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt;
    logic               misalign;

    modport master (
        output rom_addr,
        input  rom_data,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output misalign
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  misalign
    );

endinterface

// File: rtl/if_skid.sv
// One-entry hold register for the fetched word under decode back-pressure.
// dout selects the held word when valid, otherwise passes the live word.
module if_skid
    import ifetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               capture,
    input  logic               clear,
    input  logic [INSTR_W-1:0] din,
    output logic [INSTR_W-1:0] dout
);

    logic               valid;
    logic [INSTR_W-1:0] data;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= NOP;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            data  <= din;
        end
    end

    assign dout = valid ? data : din;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns fetch_pc, pairs ROM words with their PC,
// and presents them to decode with redirect, halt and skid handling.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int              ADDR_W   = 10,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DFLT
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_ctrl_if.master bus
);

    slot_e              state;
    slot_e              state_n;
    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    fetch_pc_n;
    logic [PC_W-1:0]    d_pc;
    logic [PC_W-1:0]    d_pc_n;
    logic               mis_q;
    logic               mis_n;
    logic               capture;
    logic               clear;
    logic               d_valid;
    logic               advance;
    logic               out_valid;
    logic [INSTR_W-1:0] slot_instr;

    assign d_valid = (state != SLOT_EMPTY);
    assign advance = ~bus.halt
                   & (~d_valid | bus.if_ready | bus.redirect_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SLOT_EMPTY;
            fetch_pc <= RESET_PC;
            d_pc     <= RESET_PC;
            mis_q    <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            d_pc     <= d_pc_n;
            mis_q    <= mis_n;
        end
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        d_pc_n     = d_pc;
        mis_n      = 1'b0;
        capture    = 1'b0;
        clear      = 1'b0;
        if (bus.redirect_valid) begin
            fetch_pc_n = align_pc(bus.redirect_pc);
            state_n    = SLOT_EMPTY;
            clear      = 1'b1;
            mis_n      = misaligned(bus.redirect_pc);
        end else if (advance) begin
            d_pc_n     = fetch_pc;
            state_n    = SLOT_LIVE;
            clear      = 1'b1;
            fetch_pc_n = fetch_pc + PC_STEP;
        end else if (bus.halt && d_valid && bus.if_ready) begin
            state_n = SLOT_EMPTY;
            clear   = 1'b1;
        end else if (state == SLOT_LIVE && !bus.if_ready) begin
            // ROM moves on to fetch_pc this edge; keep the word for decode
            capture = 1'b1;
            state_n = SLOT_HELD;
        end
    end

    if_skid u_skid (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .clear   (clear),
        .din     (bus.rom_data),
        .dout    (slot_instr)
    );

    assign out_valid    = d_valid & ~bus.redirect_valid;
    assign bus.rom_addr = fetch_pc[ADDR_W+1:2];
    assign bus.if_valid = out_valid;
    assign bus.if_instr = out_valid ? slot_instr : NOP;
    assign bus.if_pc    = d_pc;
    assign bus.misalign = mis_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed vector table, reset-in-stall sequence,
// then randomized traffic against a transaction-level fetch model.
module tb_ifetch_ctrl;

    localparam int ADDR_W = 10;
    localparam bit T = 1'b1;
    localparam bit F = 1'b0;

    typedef struct {
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          hlt;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] ei;
        bit          em;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    vec_t tbl[$];
    int n_vec = 0;
    int n_err = 0;

    ifetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    ifetch_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

    function automatic vec_t mk(input bit rdy, input bit rv,
                                input logic [31:0] rpc, input bit hlt,
                                input bit ev, input logic [31:0] epc,
                                input logic [31:0] ei, input bit em);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hlt = hlt;
        v.ev = ev; v.epc = epc; v.ei = ei; v.em = em;
        return v;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return 32'hA500_0000 | ((pc >> 2) & 32'h0000_03FF);
    endfunction

    task automatic drive(input bit r, input bit rdy, input bit rv,
                         input logic [31:0] rpc, input bit hlt);
        @(negedge clk);
        rst                = r;
        bus.if_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.halt           = hlt;
        #1;
    endtask

    task automatic check(input string nm, input bit ev,
                         input logic [31:0] epc, input logic [31:0] ei,
                         input bit em);
        n_vec++;
        if (bus.if_valid !== ev || bus.if_pc !== epc ||
            bus.if_instr !== ei || bus.misalign !== em) begin
            n_err++;
            $display("FAIL %s: got v=%0b pc=%h instr=%h mis=%0b want v=%0b pc=%h instr=%h mis=%0b",
                     nm, bus.if_valid, bus.if_pc, bus.if_instr, bus.misalign,
                     ev, epc, ei, em);
        end
    endtask

    // transaction-level model: current pair, next fetch target, misalign flag
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_fetch;
    bit          m_mis;

    initial begin
        bit r, rdy, rv, hlt;
        logic [31:0] rpc;
        bit ev;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA500_0000 | i;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.halt           = 1'b0;
        bus.rom_data       = 32'h0;

        // c0..c7: start-up latency, streaming, 3-cycle stall at pc 8
        tbl.push_back(mk(T, F, 0, F, F, 32'h000, 32'h0, F));
        tbl.push_back(mk(T, F, 0, F, T, 32'h000, 32'hA500_0000, F));
        tbl.push_back(mk(T, F, 0, F, T, 32'h004, 32'hA500_0001, F));
        tbl.push_back(mk(F, F, 0, F, T, 32'h008, 32'hA500_0002, F));
        tbl.push_back(mk(F, F, 0, F, T, 32'h008, 32'hA500_0002, F));
        tbl.push_back(mk(F, F, 0, F, T, 32'h008, 32'hA500_0002, F));
        tbl.push_back(mk(T, F, 0, F, T, 32'h008, 32'hA500_0002, F));
        tbl.push_back(mk(T, F, 0, F, T, 32'h00C, 32'hA500_0003, F));
        // c8..c10: redirect to 0x100
        tbl.push_back(mk(T, T, 32'h100, F, F, 32'h010, 32'h0, F));
        tbl.push_back(mk(T, F, 0, F, F, 32'h010, 32'h0, F));
        tbl.push_back(mk(T, F, 0, F, T, 32'h100, 32'hA500_0040, F));
        // c11..c14: stall, misaligned redirect while held
        tbl.push_back(mk(F, F, 0, F, T, 32'h104, 32'hA500_0041, F));
        tbl.push_back(mk(F, T, 32'h102, F, F, 32'h104, 32'h0, F));
        tbl.push_back(mk(T, F, 0, F, F, 32'h104, 32'h0, T));
        tbl.push_back(mk(T, F, 0, F, T, 32'h100, 32'hA500_0040, F));
        // c15..c18: ROM address wrap
        tbl.push_back(mk(T, T, 32'hFFC, F, F, 32'h104, 32'h0, F));
        tbl.push_back(mk(T, F, 0, F, F, 32'h104, 32'h0, F));
        tbl.push_back(mk(T, F, 0, F, T, 32'hFFC, 32'hA500_03FF, F));
        tbl.push_back(mk(T, F, 0, F, T, 32'h1000, 32'hA500_0000, F));
        // c19..c26: halt with 0x20 outstanding, release, stall
        tbl.push_back(mk(T, T, 32'h020, F, F, 32'h1004, 32'h0, F));
        tbl.push_back(mk(T, F, 0, F, F, 32'h1004, 32'h0, F));
        tbl.push_back(mk(T, F, 0, T, T, 32'h020, 32'hA500_0008, F));
        tbl.push_back(mk(T, F, 0, T, F, 32'h020, 32'h0, F));
        tbl.push_back(mk(T, F, 0, T, F, 32'h020, 32'h0, F));
        tbl.push_back(mk(T, F, 0, F, F, 32'h020, 32'h0, F));
        tbl.push_back(mk(F, F, 0, F, T, 32'h024, 32'hA500_0009, F));
        tbl.push_back(mk(F, F, 0, F, T, 32'h024, 32'hA500_0009, F));

        drive(T, F, F, 0, F);
        drive(T, F, F, 0, F);
        check("reset", F, 32'h0, 32'h0, F);
        foreach (tbl[i]) begin
            drive(F, tbl[i].rdy, tbl[i].rv, tbl[i].rpc, tbl[i].hlt);
            check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc,
                  tbl[i].ei, tbl[i].em);
        end

        // reset while HELD, then restart latency
        drive(T, F, F, 0, F);
        check("rst_pre", T, 32'h024, 32'hA500_0009, F);
        drive(F, T, F, 0, F);
        check("rst_mid_stall", F, 32'h0, 32'h0, F);
        drive(F, T, F, 0, F);
        check("restart_lat", T, 32'h0, 32'hA500_0000, F);
        drive(F, T, F, 0, F);
        check("restart_next", T, 32'h4, 32'hA500_0001, F);

        // randomized run against the model
        drive(T, F, F, 0, F);
        @(posedge clk);
        m_valid = 1'b0; m_pc = 0; m_fetch = 0; m_mis = 1'b0;
        hlt = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            r   = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 19) == 0) hlt = ~hlt;
            if ($urandom_range(0, 7) == 0)
                rpc = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
            else
                rpc = 32'($urandom_range(0, 32'h3FFF));
            drive(r, rdy, rv, rpc, hlt);
            ev = m_valid & ~rv;
            check("rand", ev, m_pc, ev ? word_of(m_pc) : 32'h0, m_mis);
            @(posedge clk);
            if (r) begin
                m_valid = 1'b0; m_pc = 0; m_fetch = 0; m_mis = 1'b0;
            end else begin
                m_mis = rv & (rpc[1:0] != 2'b00);
                if (rv) begin
                    m_fetch = rpc & 32'hFFFF_FFFC;
                    m_valid = 1'b0;
                end else if (!hlt && (!m_valid || rdy)) begin
                    m_pc    = m_fetch;
                    m_valid = 1'b1;
                    m_fetch = m_fetch + 4;
                end else if (hlt && m_valid && rdy) begin
                    m_valid = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the synchronous instruction ROM.
- Owns the fetch PC and drives the ROM word address. Pairs each returned word with its PC and presents it to decode over a valid/ready handshake.
- Handles redirects (branch/jump), decode back-pressure via a 1-entry skid buffer, and a halt request.

Parameters:
- ADDR_W, 10, ROM word-address width; rom_addr = fetch_pc[ADDR_W+1:2].
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  ADDR_W  word address to ROM; combinational from fetch_pc.
- rom_data  in  32  ROM output; registered inside the ROM, so it reflects rom_addr sampled at the previous edge.
- if_valid  out  1  instruction/PC pair valid.
- if_ready  in  1  decode accepts the pair this cycle.
- if_instr  out  32  fetched instruction; 32'h0 when !if_valid.
- if_pc  out  32  byte PC of if_instr.
- redirect_valid  in  1  load new fetch target.
- redirect_pc  in  32  target byte PC.
- halt  in  1  stop issuing new fetches.
- misalign  out  1  one-cycle pulse, registered, when an accepted redirect_pc[1:0] != 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- State:
  - fetch_pc (32b).
  - D slot: d_valid, d_pc. Meaning: the ROM is presenting mem[d_pc].
  - Skid: hold_valid, hold_instr.
- Slot FSM:
  - EMPTY (d_valid=0).
  - LIVE (d_valid=1, hold_valid=0; output from rom_data).
  - HELD (d_valid=1, hold_valid=1; output from hold_instr).
- Reset values: fetch_pc=RESET_PC, d_valid=0, d_pc=RESET_PC, hold_valid=0, hold_instr=0, misalign=0. So if_valid=0, if_instr=0, if_pc=RESET_PC.
- Output equations:
  - if_valid = d_valid & ~redirect_valid (same-cycle squash).
  - if_instr = hold_valid ? hold_instr : rom_data, gated to 0 when !if_valid.
  - if_pc = d_pc.
- advance = ~halt & (~d_valid | if_ready | redirect_valid).
- Per-edge priority:
  1. rst.
  2. redirect_valid: fetch_pc <= {redirect_pc[31:2],2'b00}; d_valid <= 0; hold_valid <= 0; misalign <= |redirect_pc[1:0].
  3. advance: d_pc <= fetch_pc; d_valid <= 1; hold_valid <= 0; fetch_pc <= fetch_pc+4.
  4. halt with d_valid & if_ready: d_valid <= 0, hold_valid <= 0, fetch_pc unchanged.
  5. Stall (LIVE & ~if_ready): hold_instr <= rom_data; hold_valid <= 1. The ROM then reads fetch_pc (=d_pc+4), so the word must be captured this edge.
  6. HELD & ~if_ready: no change.
- Latency:
  - First valid word appears in the 2nd cycle after rst deasserts: if_valid=1, if_pc=RESET_PC.
  - Steady state: one instruction per cycle while if_ready=1.
- Redirect penalty: redirect in cycle n gives cycle n+1 as a bubble, and the target is valid in cycle n+2.
- Wrap-around: fetch_pc is a full 32-bit incrementer, wrapping 0xFFFF_FFFC -> 0. rom_addr truncates, so word 2^ADDR_W-1 is followed by word 0, while if_pc keeps counting.
- Halt:
  - An outstanding D word is still delivered; no further fetch.
  - Deassert resumes at fetch_pc with the same 1-bubble timing as a redirect.
  - Redirect during halt updates fetch_pc only.
- Simultaneous events:
  - rst beats everything.
  - redirect beats stall/hold and halt.
  - A redirect while HELD discards the held word.

Decomposition:
- Package ifetch_pkg: RESET_PC default, INSTR_W=32, PC_W=32, PC_STEP=4, NOP=32'h0.
- One sub-module, if_skid: the 1-entry hold register with valid, capture/clear/select.
- Everything else is inline.

Test Plan (bench ROM model: mem[i] = 32'hA500_0000 | i):
1. Reset then if_ready=1:
   - if_valid rises 2 cycles after rst drops.
   - if_pc sequence 0,4,8,... with if_instr A500_0000, A500_0001, A500_0002.
   - No gaps.
2. Stall: if_ready=0 for 3 cycles while if_pc=8.
   - if_instr holds A500_0002, if_pc holds 8 throughout.
   - On release, next accepted pair is pc 12 / A500_0003; nothing is skipped or duplicated.
3. Redirect to 0x100 in cycle n:
   - if_valid=0 in cycle n and n+1.
   - Cycle n+2: if_pc=0x100, if_instr=A500_0040.
   - Also issued while HELD: the held word is never delivered.
4. Misaligned redirect to 0x102:
   - misalign pulses for exactly one cycle.
   - Next valid if_pc=0x100.
5. Wrap: redirect to 0xFFC (ADDR_W=10).
   - Pairs (0xFFC, A500_03FF) then (0x1000, A500_0000).
6. Halt asserted with if_pc=0x20 valid:
   - 0x20 delivered, then if_valid=0 indefinitely.
   - Release halt: if_pc=0x24 valid after 1 bubble.
   - rst mid-stall returns to the reset values.
